// File: rtl/datapath_param.sv
// Parametrised register-file datapath: single-cycle load/add/nand/noop and an
// iterative one-bit-per-cycle shift-left behind a start/busy/done handshake.
module datapath_param #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    localparam int SELW = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SELW-1:0]        SEL_A,
    input  logic [SELW-1:0]        SEL_B,
    input  logic [SELW-1:0]        SEL_W,
    input  logic [WIDTH-1:0]       IMM,
    input  logic                   sel_data,
    input  logic                   write_en,
    input  logic [1:0]             alu_op,
    output logic                   busy,
    output logic                   done,
    output logic                   flag_z,
    output logic                   flag_c,
    output logic [NREGS*WIDTH-1:0] REGS
);
    localparam int CNTW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [WIDTH-1:0]  regs_d [NREGS];
    logic              flag_z_q, flag_z_d;
    logic              flag_c_q, flag_c_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [SELW-1:0]   dst_q, dst_d;
    logic              wen_q, wen_d;

    logic              accept, shift_go, shift_end;
    logic [WIDTH-1:0]  op_a, op_b, nand_r, shifted;
    logic [WIDTH:0]    sum;

    assign accept    = start && (state_q == IDLE);
    assign shift_go  = accept && !sel_data && (alu_op == 2'b10) && (IMM != '0);
    assign shift_end = (state_q == SHIFT) && (cnt_q == CNTW'(1));
    assign op_a      = regs_q[SEL_A];
    assign op_b      = regs_q[SEL_B];
    assign sum       = {1'b0, op_a} + {1'b0, op_b};
    assign nand_r    = ~(op_a & op_b);
    assign shifted   = {sh_q[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (shift_go) state_d = SHIFT;
            SHIFT:   if (shift_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == SHIFT);
        done   = done_q;
        flag_z = flag_z_q;
        flag_c = flag_c_q;
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_regs
        assign REGS[i*WIDTH +: WIDTH] = regs_q[i];
    end

    always_comb begin
        regs_d   = regs_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        done_d   = 1'b0;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        dst_d    = dst_q;
        wen_d    = wen_q;
        if (accept) begin
            done_d = !shift_go;
            if (sel_data) begin
                if (write_en) regs_d[SEL_W] = IMM;
            end else begin
                case (alu_op)
                    2'b00: begin
                        flag_c_d = sum[WIDTH];
                        flag_z_d = (sum[WIDTH-1:0] == '0);
                        if (write_en) regs_d[SEL_W] = sum[WIDTH-1:0];
                    end
                    2'b01: begin
                        flag_z_d = (nand_r == '0);
                        if (write_en) regs_d[SEL_W] = nand_r;
                    end
                    2'b10: begin
                        if (IMM == '0) begin
                            flag_c_d = 1'b0;
                            flag_z_d = (op_a == '0);
                            if (write_en) regs_d[SEL_W] = op_a;
                        end else begin
                            // Destination and write enable are latched so the
                            // result lands at completion regardless of later inputs.
                            sh_d  = op_a;
                            cnt_d = (32'(IMM) >= 32'(WIDTH)) ? CNTW'(WIDTH) : CNTW'(IMM);
                            dst_d = SEL_W;
                            wen_d = write_en;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (state_q == SHIFT) begin
            sh_d  = shifted;
            cnt_d = cnt_q - CNTW'(1);
            if (shift_end) begin
                flag_c_d = sh_q[WIDTH-1];
                flag_z_d = (shifted == '0);
                done_d   = 1'b1;
                if (wen_q) regs_d[dst_q] = shifted;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            done_q   <= 1'b0;
            sh_q     <= '0;
            cnt_q    <= '0;
            dst_q    <= '0;
            wen_q    <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            done_q   <= done_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            dst_q    <= dst_d;
            wen_q    <= wen_d;
        end
    end
endmodule

// File: tb/tb_datapath_param.sv
// Randomised bench for datapath_param against an arithmetic reference model,
// plus directed reset, shift and 8x8 parameter checks.
module tb_datapath_param;
    localparam int W = 4, N = 4, SW = 2;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, sel_data = 1'b0, write_en = 1'b0;
    logic [SW-1:0] sel_a = '0, sel_b = '0, sel_w = '0;
    logic [W-1:0] imm = '0;
    logic [1:0] alu_op = '0;
    logic busy, done, flag_z, flag_c;
    logic [N*W-1:0] regs;

    logic start8 = 1'b0, sel_data8 = 1'b0, write_en8 = 1'b0;
    logic [2:0] sel_a8 = '0, sel_b8 = '0, sel_w8 = '0;
    logic [7:0] imm8 = '0;
    logic [1:0] alu_op8 = '0;
    logic busy8, done8, flag_z8, flag_c8;
    logic [63:0] regs8;

    always #5 clk = ~clk;

    datapath_param #(.WIDTH(W), .NREGS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .SEL_A(sel_a), .SEL_B(sel_b), .SEL_W(sel_w),
        .IMM(imm), .sel_data(sel_data), .write_en(write_en), .alu_op(alu_op),
        .busy(busy), .done(done), .flag_z(flag_z), .flag_c(flag_c), .REGS(regs));

    datapath_param #(.WIDTH(8), .NREGS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .SEL_A(sel_a8), .SEL_B(sel_b8), .SEL_W(sel_w8),
        .IMM(imm8), .sel_data(sel_data8), .write_en(write_en8), .alu_op(alu_op8),
        .busy(busy8), .done(done8), .flag_z(flag_z8), .flag_c(flag_c8), .REGS(regs8));

    int n_vec = 0, n_err = 0;
    int m_r[N];
    int m_z = 0, m_c = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_pack();
        logic [63:0] v = '0;
        for (int i = 0; i < N; i++) v |= 64'(m_r[i]) << (i * W);
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_r[i] = 0;
        m_z = 0;
        m_c = 0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_regs"}, 64'(regs), m_pack());
        chk({tag, "_z"}, 64'(flag_z), 64'(m_z));
        chk({tag, "_c"}, 64'(flag_c), 64'(m_c));
    endtask

    task automatic drive(input bit sd, input bit we, input int op, input int a, input int b,
                         input int w, input int im);
        sel_data = sd; write_en = we; alu_op = op[1:0];
        sel_a = a[SW-1:0]; sel_b = b[SW-1:0]; sel_w = w[SW-1:0]; imm = im[W-1:0];
        start = 1'b1;
    endtask

    // Issue one instruction, follow it to completion and check against the model.
    task automatic exec(input bit sd, input bit we, input int op, input int a, input int b,
                        input int w, input int im);
        int k, ra, rb, res, full;
        k = (!sd && op == 2 && im != 0) ? ((im > W) ? W : im) : 0;
        @(negedge clk);
        drive(sd, we, op, a, b, w, im);
        ra = m_r[a];
        rb = m_r[b];
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < k; i++) begin
            chk("shift_busy", 64'(busy), 64'd1);
            chk("shift_nodone", 64'(done), 64'd0);
            chk("shift_hold", 64'(regs), m_pack());
            @(negedge clk);
            drive($urandom_range(1), 1'b1, $urandom_range(3), $urandom_range(3),
                  $urandom_range(3), $urandom_range(3), $urandom_range(MASK));
            @(posedge clk); #1 start = 1'b0;
        end
        res = -1;
        if (sd) begin
            if (we) m_r[w] = im;
        end else begin
            case (op)
                0: begin full = ra + rb; res = full & MASK; m_c = (full >> W) & 1; end
                1: res = ~(ra & rb) & MASK;
                2: begin full = ra << k; res = full & MASK; m_c = (full >> W) & 1; end
                default: ;
            endcase
            if (res >= 0) begin
                m_z = (res == 0);
                if (we) m_r[w] = res;
            end
        end
        chk("exec_busy", 64'(busy), 64'd0);
        chk("exec_done", 64'(done), 64'd1);
        chk_state("exec");
        if (k > 0) begin
            @(posedge clk); #1;
            chk("done_pulse", 64'(done), 64'd0);
        end
    endtask

    task automatic exec8(input bit sd, input int op, input int a, input int b, input int w,
                         input int im, output int bcyc);
        @(negedge clk);
        sel_data8 = sd; write_en8 = 1'b1; alu_op8 = op[1:0];
        sel_a8 = a[2:0]; sel_b8 = b[2:0]; sel_w8 = w[2:0]; imm8 = im[7:0];
        start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        bcyc = 0;
        while (busy8 && bcyc < 20) begin
            bcyc++;
            @(posedge clk); #1;
        end
        chk("w8_done", 64'(done8), 64'd1);
    endtask

    initial begin
        int bc;
        m_reset();
        #1;
        chk_state("reset");
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        @(negedge clk) rst = 1'b0;

        exec(1, 1, 3, 0, 0, 0, 'h0);
        exec(1, 1, 3, 0, 0, 1, 'hF);
        exec(1, 1, 3, 0, 0, 2, 'h2);
        exec(1, 1, 3, 0, 0, 3, 'hD);
        chk("loads", 64'(regs), 64'hD2F0);

        exec(0, 1, 0, 1, 2, 0, 0);
        chk("add_r0", 64'(regs[3:0]), 64'h1);
        chk("add_c", 64'(flag_c), 64'd1);
        exec(0, 1, 1, 1, 1, 3, 0);
        chk("nand_r3", 64'(regs[15:12]), 64'h0);
        chk("nand_z", 64'(flag_z), 64'd1);
        exec(0, 0, 0, 2, 2, 1, 0);

        exec(0, 1, 2, 2, 0, 2, 3);
        chk("shl3_r2", 64'(regs[11:8]), 64'h0);
        chk("shl3_c", 64'(flag_c), 64'd1);
        exec(0, 1, 2, 1, 0, 1, 9);
        chk("shl9_r1", 64'(regs[7:4]), 64'h0);
        exec(1, 1, 3, 0, 0, 3, 'h9);
        exec(0, 1, 2, 3, 0, 0, 0);
        chk("shl0_c", 64'(flag_c), 64'd0);

        @(negedge clk); #2 rst = 1'b1;
        #1;
        m_reset();
        chk_state("async_rst");
        chk("async_rst_done", 64'(done), 64'd0);
        @(negedge clk) rst = 1'b0;

        exec(1, 1, 3, 0, 0, 2, 'h2);
        exec(1, 1, 3, 0, 0, 1, 'h5);
        @(negedge clk);
        drive(0, 1, 2, 2, 0, 2, 3);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        m_reset();
        chk_state("midshift_rst");
        chk("midshift_busy", 64'(busy), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("midshift_nodone", 64'(done), 64'd0);
        exec(1, 1, 3, 0, 0, 1, 'h7);

        repeat (300) begin
            exec(($urandom_range(3) == 0), $urandom_range(1), $urandom_range(3),
                 $urandom_range(N - 1), $urandom_range(N - 1), $urandom_range(N - 1),
                 $urandom_range(MASK));
        end

        exec8(1, 3, 0, 0, 7, 'hFF, bc);
        chk("w8_load", 64'(regs8[63:56]), 64'hFF);
        exec8(0, 0, 7, 7, 6, 0, bc);
        chk("w8_add", 64'(regs8[55:48]), 64'hFE);
        chk("w8_add_c", 64'(flag_c8), 64'd1);
        exec8(0, 2, 6, 0, 5, 1, bc);
        chk("w8_shl", 64'(regs8[47:40]), 64'hFC);
        chk("w8_shl_c", 64'(flag_c8), 64'd1);
        chk("w8_shl_busy", 64'(bc), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
